// File: rtl/rv32_instr_encoder_pkg.sv
// rv32_instr_encoder_pkg: shared RV32I immediate-format enum, opcodes and range helper
package rv32_instr_encoder_pkg;
    typedef enum logic [2:0] {
        IMMSRC_R_TYPE = 3'd0,
        IMMSRC_I_TYPE = 3'd1,
        IMMSRC_S_TYPE = 3'd2,
        IMMSRC_B_TYPE = 3'd3,
        IMMSRC_U_TYPE = 3'd4,
        IMMSRC_J_TYPE = 3'd5
    } ImmSrc_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // True when imm is the sign extension of its low w bits.
    function automatic logic imm_fits(input logic [31:0] imm, input int w);
        logic signed [31:0] s;
        s = imm << (32 - w);
        return $unsigned(s >>> (32 - w)) == imm;
    endfunction
endpackage

// File: rtl/rv32_instr_encoder_if.sv
// rv32_instr_encoder_if: request/instruction stream bundle for the instruction encoder
interface rv32_instr_encoder_if import rv32_instr_encoder_pkg::*; #(parameter int CNT_W = 16) ();
    logic             req_valid;
    logic             req_ready;
    ImmSrc_t          req_fmt;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [31:0]      req_imm;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             instr_err;
    logic [CNT_W-1:0] emit_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
        input  req_ready, instr_valid, instr, instr_err, emit_cnt, err_cnt
    );
    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
        output req_ready, instr_valid, instr, instr_err, emit_cnt, err_cnt
    );
endinterface

// File: rtl/rv32_instr_encoder_field_pack.sv
// rv32_field_pack: combinational RV32I field packer with immediate range checking
module rv32_field_pack import rv32_instr_encoder_pkg::*; (
    input  ImmSrc_t     fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        err,
    output logic [31:0] word
);
    always_comb begin
        err  = 1'b0;
        word = '0;
        case (fmt)
            IMMSRC_R_TYPE: word = {funct7, rs2, rs1, funct3, rd, opcode};
            IMMSRC_I_TYPE: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !imm_fits(imm, 12);
            end
            IMMSRC_S_TYPE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !imm_fits(imm, 12);
            end
            IMMSRC_B_TYPE: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !imm_fits(imm, 13) | imm[0];
            end
            IMMSRC_U_TYPE: begin
                word = {imm[31:12], rd, opcode};
                err  = |imm[11:0];
            end
            IMMSRC_J_TYPE: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !imm_fits(imm, 21) | imm[0];
            end
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: streaming RV32I encoder with output FIFO and emit/error counters
module rv32_instr_encoder import rv32_instr_encoder_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    rv32_instr_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   word;
    logic          err, push, pop;

    rv32_field_pack u_pack (
        .fmt(bus.req_fmt), .opcode(bus.req_opcode), .funct3(bus.req_funct3), .funct7(bus.req_funct7),
        .rd(bus.req_rd), .rs1(bus.req_rs1), .rs2(bus.req_rs2), .imm(bus.req_imm), .err(err), .word(word)
    );

    assign bus.req_ready   = count != FULL;
    assign bus.instr_valid = count != '0;
    assign bus.instr       = bus.instr_valid ? mem[head][31:0] : '0;
    assign bus.instr_err   = bus.instr_valid & mem[head][32];
    assign push            = bus.req_valid & bus.req_ready;
    assign pop             = bus.instr_valid & bus.instr_ready;

    always_ff @(posedge clk)
        if (push) mem[tail] <= {err, word};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            bus.emit_cnt <= '0;
            bus.err_cnt  <= '0;
        end else begin
            head         <= head + AW'(pop);
            tail         <= tail + AW'(push);
            count        <= count + (AW+1)'(push) - (AW+1)'(pop);
            bus.emit_cnt <= bus.emit_cnt + CNT_W'(pop);
            bus.err_cnt  <= bus.err_cnt + CNT_W'(pop & bus.instr_err);
        end
    end
endmodule
